// File: rtl/histeq_pkg.sv
// Shared state encoding, sizing constants and scale-factor helper for the
// histogram-equalization frame controller.
package histeq_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLEAR = 3'd1,
    ACCUM = 3'd2,
    SCAN  = 3'd3,
    DONE  = 3'd4
  } state_t;

  localparam int NUM_LEVELS = 256;
  localparam int PIX_W      = 8;

  // ceil(255 * 2^shift / image_size): a full-frame cdf maps to at least 255.
  function automatic int unsigned calc_scale_mul(input longint unsigned image_size,
                                                 input int unsigned     shift);
    longint unsigned num;
    num = 64'd255 << shift;
    return 32'((num + image_size - 64'd1) / image_size);
  endfunction

endpackage

// File: rtl/histeq_scale.sv
// Two-stage capture/multiply/saturate pipeline turning a cumulative count into
// an 8-bit equalized level; valid and address travel alongside the data.
module histeq_scale
  import histeq_pkg::*;
#(
  parameter int CNT_W     = 19,
  parameter int SHIFT     = 24,
  parameter int SCALE_MUL = 13927
) (
  input  logic             i_clk,
  input  logic             i_reset_n,
  input  logic             i_flush,
  input  logic             i_valid,
  input  logic [PIX_W-1:0] i_addr,
  input  logic [CNT_W-1:0] i_cdf,
  output logic             o_valid,
  output logic [PIX_W-1:0] o_addr,
  output logic [PIX_W-1:0] o_data
);

  localparam int MUL_W   = $clog2(SCALE_MUL + 1);
  localparam int PROD_W  = CNT_W + MUL_W;
  localparam int PIX_MAX = (1 << PIX_W) - 1;

  logic             s1_valid;
  logic [PIX_W-1:0] s1_addr;
  logic [CNT_W-1:0] s1_cdf;
  logic [PROD_W-1:0] product;
  logic [PROD_W-1:0] scaled;
  logic [PIX_W-1:0]  level;

  // Full-width product, so the shift sees every bit before saturation.
  always_comb begin
    product = PROD_W'(s1_cdf) * PROD_W'(SCALE_MUL);
    scaled  = product >> SHIFT;
    level   = (scaled > PROD_W'(PIX_MAX)) ? {PIX_W{1'b1}} : scaled[PIX_W-1:0];
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset_n || i_flush) begin
      s1_valid <= 1'b0;
      o_valid  <= 1'b0;
    end else begin
      s1_valid <= i_valid;
      o_valid  <= s1_valid;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      s1_addr <= '0;
      s1_cdf  <= '0;
      o_addr  <= '0;
      o_data  <= '0;
    end else begin
      s1_addr <= i_addr;
      s1_cdf  <= i_cdf;
      o_addr  <= s1_addr;
      o_data  <= level;
    end
  end

endmodule

// File: rtl/histeq_frame_ctrl.sv
// Frame sequencer: clear counters, accumulate IMAGE_SIZE pixels, scan the cdf into
// the mapping LUT. Define HISTEQ_OVERRUN_CNT_EN to add the o_overrun_cnt output.
module histeq_frame_ctrl
  import histeq_pkg::*;
#(
  parameter int IMAGE_SIZE = 640 * 480,
  parameter int CNT_W      = $clog2(IMAGE_SIZE + 1),
  parameter int SHIFT      = 24,
  parameter int SCALE_MUL  = int'(calc_scale_mul(64'(IMAGE_SIZE), 32'(SHIFT)))
) (
  input  logic             i_clk,
  input  logic             i_reset_n,
  input  logic             i_start,
  input  logic             i_abort,
  input  logic             i_pixel_valid,
  output logic             o_pixel_ready,
  output logic             o_hist_reset_n,
  output logic             o_hist_pixel_valid,
  output logic [PIX_W-1:0] o_cum_sel,
  input  logic [CNT_W-1:0] i_cum_hist,
  output logic             o_lut_we,
  output logic [PIX_W-1:0] o_lut_addr,
  output logic [PIX_W-1:0] o_lut_data,
  output logic             o_busy,
  output logic             o_lut_done,
`ifdef HISTEQ_OVERRUN_CNT_EN
  output logic [15:0]      o_overrun_cnt,
`endif
  output state_t           o_dbg_state
);

  localparam int IDX_W     = $clog2(NUM_LEVELS + 2);
  localparam int SCAN_LAST = NUM_LEVELS + 1;

  state_t           state;
  state_t           state_nx;
  logic [CNT_W-1:0] pix_cnt;
  logic [IDX_W-1:0] scan_idx;
  logic             pix_fire;
  logic             last_pix;
  logic             scan_issue;

  // Pixel handshake: a pixel transfers on any cycle with i_pixel_valid and
  // o_pixel_ready both high; the source cannot be stalled, only dropped.
  assign pix_fire   = (state == ACCUM) && i_pixel_valid;
  assign last_pix   = pix_fire && (pix_cnt == CNT_W'(IMAGE_SIZE - 1));
  assign scan_issue = (state == SCAN) && (scan_idx < IDX_W'(NUM_LEVELS));

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx           = state;
    o_pixel_ready      = 1'b0;
    o_hist_reset_n     = 1'b1;
    o_hist_pixel_valid = 1'b0;
    o_cum_sel          = '0;
    o_busy             = 1'b1;
    o_lut_done         = 1'b0;
    unique case (state)
      IDLE: begin
        o_busy = 1'b0;
        if (i_start) state_nx = CLEAR;
      end
      CLEAR: begin
        o_hist_reset_n = 1'b0;
        state_nx       = ACCUM;
      end
      ACCUM: begin
        o_pixel_ready      = 1'b1;
        o_hist_pixel_valid = i_pixel_valid;
        if (last_pix) state_nx = SCAN;
      end
      SCAN: begin
        // The last two SCAN cycles only drain the pipeline; the mux select idles at 0.
        if (scan_issue) o_cum_sel = scan_idx[PIX_W-1:0];
        if (scan_idx == IDX_W'(SCAN_LAST)) state_nx = DONE;
      end
      DONE: begin
        o_lut_done = 1'b1;
        state_nx   = IDLE;
      end
      default: state_nx = IDLE;
    endcase
    if (i_abort) state_nx = IDLE;
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      pix_cnt <= '0;
    end else if (state == CLEAR) begin
      pix_cnt <= '0;
    end else if (pix_fire) begin
      pix_cnt <= pix_cnt + 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      scan_idx <= '0;
    end else if ((state == SCAN) && !i_abort) begin
      scan_idx <= scan_idx + 1'b1;
    end else begin
      scan_idx <= '0;
    end
  end

  histeq_scale #(
    .CNT_W     (CNT_W),
    .SHIFT     (SHIFT),
    .SCALE_MUL (SCALE_MUL)
  ) u_scale (
    .i_clk     (i_clk),
    .i_reset_n (i_reset_n),
    .i_flush   (i_abort),
    .i_valid   (scan_issue),
    .i_addr    (scan_idx[PIX_W-1:0]),
    .i_cdf     (i_cum_hist),
    .o_valid   (o_lut_we),
    .o_addr    (o_lut_addr),
    .o_data    (o_lut_data)
  );

`ifdef HISTEQ_OVERRUN_CNT_EN
  // Valids arriving mid-frame but outside ACCUM are pixels the frame lost.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      o_overrun_cnt <= '0;
    end else if (state == CLEAR) begin
      o_overrun_cnt <= '0;
    end else if (i_pixel_valid && (state != ACCUM) && (state != IDLE) &&
                 (o_overrun_cnt != 16'hFFFF)) begin
      o_overrun_cnt <= o_overrun_cnt + 16'd1;
    end
  end
`endif

  assign o_dbg_state = state;

endmodule

// File: tb/tb_histeq_frame_ctrl.sv
// Bench for histeq_frame_ctrl: a 16-pixel instance and a 4-pixel instance using the
// full-frame arithmetic widths, checked against a formula-based LUT model.
`timescale 1ns/1ps
module tb_histeq_frame_ctrl;
  import histeq_pkg::*;

  localparam int N_IMG = 16;
  localparam int N_CW  = 5;
  localparam int N_SH  = 8;
  localparam int N_MUL = 4080;
  localparam int W_IMG = 4;
  localparam int W_CW  = 19;
  localparam int W_SH  = 24;
  localparam int W_MUL = 13927;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  logic start = 1'b0, abort = 1'b0, pix_valid = 1'b0, sel_w = 1'b0;
  logic [W_CW-1:0] cum_tbl [NUM_LEVELS];

  logic n_ready, n_hrst_n, n_hvalid, n_we, n_busy, n_done;
  logic [7:0] n_sel, n_addr, n_data;
  logic [N_CW-1:0] n_cum;
  state_t n_state;
  logic w_ready, w_hrst_n, w_hvalid, w_we, w_busy, w_done;
  logic [7:0] w_sel, w_addr, w_data;
  logic [W_CW-1:0] w_cum;
  state_t w_state;
`ifdef HISTEQ_OVERRUN_CNT_EN
  logic [15:0] n_ovr, w_ovr;
`endif

  assign n_cum = cum_tbl[n_sel][N_CW-1:0];
  assign w_cum = cum_tbl[w_sel];

  histeq_frame_ctrl #(.IMAGE_SIZE(N_IMG), .CNT_W(N_CW), .SHIFT(N_SH), .SCALE_MUL(N_MUL)) dut_n (
    .i_clk(clk), .i_reset_n(reset_n), .i_start(start & ~sel_w), .i_abort(abort & ~sel_w),
    .i_pixel_valid(pix_valid & ~sel_w), .o_pixel_ready(n_ready), .o_hist_reset_n(n_hrst_n),
    .o_hist_pixel_valid(n_hvalid), .o_cum_sel(n_sel), .i_cum_hist(n_cum), .o_lut_we(n_we),
    .o_lut_addr(n_addr), .o_lut_data(n_data), .o_busy(n_busy), .o_lut_done(n_done),
`ifdef HISTEQ_OVERRUN_CNT_EN
    .o_overrun_cnt(n_ovr),
`endif
    .o_dbg_state(n_state));

  histeq_frame_ctrl #(.IMAGE_SIZE(W_IMG), .CNT_W(W_CW), .SHIFT(W_SH), .SCALE_MUL(W_MUL)) dut_w (
    .i_clk(clk), .i_reset_n(reset_n), .i_start(start & sel_w), .i_abort(abort & sel_w),
    .i_pixel_valid(pix_valid & sel_w), .o_pixel_ready(w_ready), .o_hist_reset_n(w_hrst_n),
    .o_hist_pixel_valid(w_hvalid), .o_cum_sel(w_sel), .i_cum_hist(w_cum), .o_lut_we(w_we),
    .o_lut_addr(w_addr), .o_lut_data(w_data), .o_busy(w_busy), .o_lut_done(w_done),
`ifdef HISTEQ_OVERRUN_CNT_EN
    .o_overrun_cnt(w_ovr),
`endif
    .o_dbg_state(w_state));

  // Outputs of whichever instance is under test.
  logic m_ready, m_hrst_n, m_hvalid, m_we, m_busy, m_done;
  logic [7:0] m_sel, m_addr, m_data;
  state_t m_state;
  assign m_ready  = sel_w ? w_ready  : n_ready;
  assign m_hrst_n = sel_w ? w_hrst_n : n_hrst_n;
  assign m_hvalid = sel_w ? w_hvalid : n_hvalid;
  assign m_we     = sel_w ? w_we     : n_we;
  assign m_busy   = sel_w ? w_busy   : n_busy;
  assign m_done   = sel_w ? w_done   : n_done;
  assign m_sel    = sel_w ? w_sel    : n_sel;
  assign m_addr   = sel_w ? w_addr   : n_addr;
  assign m_data   = sel_w ? w_data   : n_data;
  assign m_state  = sel_w ? w_state  : n_state;
`ifdef HISTEQ_OVERRUN_CNT_EN
  logic [15:0] m_ovr;
  assign m_ovr = sel_w ? w_ovr : n_ovr;
`endif

  // ---------------- model and scoreboard ----------------
  int n_checks = 0;
  int n_pass = 0;
  int img_size;
  int shift_v;
  longint unsigned mul_v;
  longint unsigned cdf_max;
  logic [15:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [7:0] eq_level(input longint unsigned cdf);
    longint unsigned v;
    v = (cdf * mul_v) >> shift_v;
    return (v > 64'd255) ? 8'd255 : v[7:0];
  endfunction

  task automatic select(input bit w);
    sel_w    = w;
    img_size = w ? W_IMG : N_IMG;
    shift_v  = w ? W_SH : N_SH;
    mul_v    = w ? 64'(W_MUL) : 64'(N_MUL);
    cdf_max  = w ? 64'((1 << W_CW) - 1) : 64'((1 << N_CW) - 1);
  endtask

  // ---------------- driver tasks ----------------
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_state"}, 32'(m_state), 32'(IDLE));
    check({tag, "_busy"},  32'(m_busy),   32'd0);
    check({tag, "_ready"}, 32'(m_ready),  32'd0);
    check({tag, "_hrstn"}, 32'(m_hrst_n), 32'd1);
    check({tag, "_hval"},  32'(m_hvalid), 32'd0);
    check({tag, "_we"},    32'(m_we),     32'd0);
    check({tag, "_done"},  32'(m_done),   32'd0);
    check({tag, "_sel"},   32'(m_sel),    32'd0);
  endtask

  // pat: 0 random, 1 step 8/16, 2 all 153600, 3 all 307200. abort_at < 0: no abort.
  task automatic run_frame(input int pat, input int abort_at, input bit noisy);
    int fwd;
    int cyc;
    int ovr_exp;
    logic [15:0] e;
    for (int k = 0; k < NUM_LEVELS; k++) begin
      case (pat)
        1:       cum_tbl[k] = (k < 100) ? W_CW'(8) : W_CW'(16);
        2:       cum_tbl[k] = W_CW'(153600);
        3:       cum_tbl[k] = W_CW'(307200);
        default: cum_tbl[k] = W_CW'($urandom_range(0, 32'(cdf_max)));
      endcase
    end
    exp_q.delete();
    for (int k = 0; k < NUM_LEVELS; k++) exp_q.push_back({8'(k), eq_level(64'(cum_tbl[k]))});

    start = 1'b1;
    pix_valid = 1'b0;
    @(negedge clk);
    check("start_idle", 32'(m_busy), 32'd0);
    next_cycle();
    start = 1'b0;
    @(negedge clk);
    check("clear_hrstn", 32'(m_hrst_n), 32'd0);
    check("clear_busy",  32'(m_busy),   32'd1);
    check("clear_ready", 32'(m_ready),  32'd0);
    next_cycle();

    fwd = 0;
    cyc = 0;
    while (fwd < img_size && cyc < 1000) begin
      pix_valid = ($urandom_range(0, 2) != 0);
      start = noisy && ($urandom_range(0, 5) == 0);
      @(negedge clk);
      check("accum_state", 32'(m_state),  32'(ACCUM));
      check("accum_ready", 32'(m_ready),  32'd1);
      check("accum_fwd",   32'(m_hvalid), 32'(pix_valid));
`ifdef HISTEQ_OVERRUN_CNT_EN
      check("ovr_cleared", 32'(m_ovr), 32'd0);
`endif
      if (pix_valid) fwd++;
      next_cycle();
      cyc++;
    end
    pix_valid = 1'b0;
    start = 1'b0;

    ovr_exp = 0;
    for (int c = 0; c < NUM_LEVELS + 2; c++) begin
      pix_valid = noisy && ($urandom_range(0, 1) == 1);
      start = noisy && (c == 100);
      abort = (c == abort_at);
      @(negedge clk);
      check("scan_state", 32'(m_state),  32'(SCAN));
      check("scan_ready", 32'(m_ready),  32'd0);
      check("scan_hval",  32'(m_hvalid), 32'd0);
      if (c < NUM_LEVELS) check("scan_sel", 32'(m_sel), 32'(c));
      if (c >= 2) begin
        check("scan_we", 32'(m_we), 32'd1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check("lut_addr", 32'(m_addr), 32'(e[15:8]));
          check("lut_data", 32'(m_data), 32'(e[7:0]));
        end else begin
          check("lut_extra_write", 32'(m_addr), 32'hFFFF);
        end
      end else begin
        check("scan_we_fill", 32'(m_we), 32'd0);
      end
      if (pix_valid) ovr_exp++;
      next_cycle();
      if (abort) begin
        abort = 1'b0;
        pix_valid = 1'b0;
        start = 1'b0;
        for (int j = 0; j < 4; j++) begin
          @(negedge clk);
          check_idle("post_abort");
          next_cycle();
        end
        return;
      end
    end
    start = 1'b0;

    pix_valid = noisy && ($urandom_range(0, 1) == 1);
    @(negedge clk);
    check("done_pulse", 32'(m_done),  32'd1);
    check("done_state", 32'(m_state), 32'(DONE));
    check("done_we",    32'(m_we),    32'd0);
    if (pix_valid) ovr_exp++;
    next_cycle();
    pix_valid = 1'b0;
    @(negedge clk);
    check_idle("after_done");
    check("lut_all_written", 32'(exp_q.size()), 32'd0);
`ifdef HISTEQ_OVERRUN_CNT_EN
    check("ovr_count", 32'(m_ovr), 32'(ovr_exp));
`endif
    next_cycle();
  endtask

  task automatic reset_mid_accum();
    start = 1'b1;
    next_cycle();
    start = 1'b0;
    repeat (3) begin
      pix_valid = 1'b1;
      next_cycle();
    end
    reset_n = 1'b0;
    next_cycle();
    @(negedge clk);
    check_idle("mid_reset");
    check("mid_reset_addr", 32'(m_addr), 32'd0);
    check("mid_reset_data", 32'(m_data), 32'd0);
    next_cycle();
    reset_n = 1'b1;
    pix_valid = 1'b0;
    next_cycle();
  endtask

  task automatic start_with_abort();
    start = 1'b1;
    abort = 1'b1;
    next_cycle();
    start = 1'b0;
    abort = 1'b0;
    @(negedge clk);
    check_idle("start_abort");
    next_cycle();
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    select(1'b0);
    for (int k = 0; k < NUM_LEVELS; k++) cum_tbl[k] = '0;
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    check_idle("reset");
    check("reset_addr", 32'(m_addr), 32'd0);
    check("reset_data", 32'(m_data), 32'd0);
`ifdef HISTEQ_OVERRUN_CNT_EN
    check("reset_ovr", 32'(m_ovr), 32'd0);
`endif
    next_cycle();
    reset_n = 1'b1;
    next_cycle();

    run_frame(1, -1, 1'b0);
    run_frame(0, -1, 1'b1);
    run_frame(0, 40, 1'b0);
    run_frame(0, -1, 1'b0);
    start_with_abort();
    reset_mid_accum();
    run_frame(0, -1, 1'b1);
    run_frame(0, 1, 1'b1);

    select(1'b1);
    run_frame(2, -1, 1'b0);
    run_frame(3, -1, 1'b0);
    run_frame(0, -1, 1'b1);
    run_frame(0, 200, 1'b1);
    run_frame(0, -1, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got no end of sequence, required completion");
    $fatal(1, "watchdog");
  end

endmodule
